// File: rtl/vx_smem_pkg.sv
// vx_smem_pkg: shared constants and request/response types for vx_smem_responder
package vx_smem_pkg;
  localparam int NUM_REQS      = 4;
  localparam int NUM_BANKS     = 4;
  localparam int SIZE          = 16384;
  localparam int TAG_WIDTH     = 8;
  localparam int ROWS          = SIZE / (4 * NUM_BANKS);
  localparam int BANK_SEL_BITS = $clog2(NUM_BANKS);
  localparam int ROW_BITS      = $clog2(ROWS);
  typedef struct packed {
    logic                 rw;
    logic [29:0]          addr;
    logic [3:0]           byteen;
    logic [31:0]          data;
    logic [TAG_WIDTH-1:0] tag;
  } smem_req_t;
  typedef struct packed {
    logic [NUM_REQS-1:0]       tmask;
    logic [NUM_REQS-1:0][31:0] data;
    logic [TAG_WIDTH-1:0]      tag;
  } smem_rsp_t;
endpackage

// File: rtl/vx_smem_bank.sv
// vx_smem_bank: single-port word bank with byte-write enable and registered read
module vx_smem_bank
  import vx_smem_pkg::*;
(
  input  logic                clk,
  input  logic                en,
  input  logic                we,
  input  logic [3:0]          byteen,
  input  logic [ROW_BITS-1:0] addr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata
);
  logic [31:0] mem [ROWS];
  // rdata only moves on a read so a held response keeps its data
  always_ff @(posedge clk)
    if (en && we) begin
      for (int k = 0; k < 4; k++)
        if (byteen[k]) mem[addr][k*8 +: 8] <= wdata[k*8 +: 8];
    end else if (en) rdata <= mem[addr];
endmodule

// File: rtl/vx_smem_responder.sv
// vx_smem_responder: banked shared-memory responder; define SMEM_RD_BCAST_EN for same-word read broadcast
module vx_smem_responder
  import vx_smem_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQS-1:0]           req_valid,
  input  logic [NUM_REQS-1:0]           req_rw,
  input  logic [NUM_REQS*30-1:0]        req_addr,
  input  logic [NUM_REQS*4-1:0]         req_byteen,
  input  logic [NUM_REQS*32-1:0]        req_data,
  input  logic [NUM_REQS*TAG_WIDTH-1:0] req_tag,
  output logic [NUM_REQS-1:0]           req_ready,
  output logic                          rsp_valid,
  output logic [NUM_REQS-1:0]           rsp_tmask,
  output logic [NUM_REQS*32-1:0]        rsp_data,
  output logic [TAG_WIDTH-1:0]          rsp_tag,
  input  logic                          rsp_ready
);
  smem_req_t                req [NUM_REQS];
  smem_rsp_t                rsp;
  logic [BANK_SEL_BITS-1:0] bank [NUM_REQS];
  logic [BANK_SEL_BITS-1:0] rsp_bank [NUM_REQS];
  logic [TAG_WIDTH-1:0]     leader_tag, tag_q;
  logic [NUM_REQS-1:0]      cand, win, acc, fire_rd, tmask_q;
  logic                     stall;
  logic [NUM_BANKS-1:0]     bank_en, bank_we;
  logic [3:0]               bank_be [NUM_BANKS];
  logic [ROW_BITS-1:0]      bank_row [NUM_BANKS];
  logic [31:0]              bank_wdata [NUM_BANKS];
  logic [31:0]              bank_rdata [NUM_BANKS];
  always_comb begin
    leader_tag = '0;
    for (int i = NUM_REQS - 1; i >= 0; i--) begin
      req[i]  = {req_rw[i], req_addr[i*30 +: 30], req_byteen[i*4 +: 4], req_data[i*32 +: 32], req_tag[i*TAG_WIDTH +: TAG_WIDTH]};
      bank[i] = req[i].addr[BANK_SEL_BITS-1:0];
      if (req_valid[i]) leader_tag = req[i].tag;
    end
  end
  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) cand[i] = req_valid[i] && req[i].tag == leader_tag;
    win = cand;
    for (int i = 0; i < NUM_REQS; i++)
      for (int j = 0; j < NUM_REQS; j++)
        if (j < i && cand[j] && bank[j] == bank[i]) win[i] = 1'b0;
    acc = win;
`ifdef SMEM_RD_BCAST_EN
    // a losing read rides along when its bank winner reads the very same word
    for (int i = 0; i < NUM_REQS; i++)
      for (int j = 0; j < NUM_REQS; j++)
        if (j < i && win[j] && cand[i] && bank[j] == bank[i] && !req[i].rw && !req[j].rw && req[i].addr == req[j].addr) acc[i] = 1'b1;
`endif
  end
  assign stall     = rsp_valid && !rsp_ready;
  assign req_ready = stall ? '0 : acc;
  assign fire_rd   = req_ready & ~req_rw;
  always_comb begin
    bank_en = '0;
    bank_we = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_be[b]    = '0;
      bank_row[b]   = '0;
      bank_wdata[b] = '0;
    end
    for (int i = 0; i < NUM_REQS; i++)
      if (win[i] && !stall) begin
        bank_en[bank[i]]    = 1'b1;
        bank_we[bank[i]]    = req[i].rw;
        bank_be[bank[i]]    = req[i].byteen;
        bank_row[bank[i]]   = req[i].addr[BANK_SEL_BITS +: ROW_BITS];
        bank_wdata[bank[i]] = req[i].data;
      end
  end
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    vx_smem_bank u_bank (
      .clk   (clk),
      .en    (bank_en[b]),
      .we    (bank_we[b]),
      .byteen(bank_be[b]),
      .addr  (bank_row[b]),
      .wdata (bank_wdata[b]),
      .rdata (bank_rdata[b])
    );
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rsp_valid <= 1'b0;
      tmask_q   <= '0;
      tag_q     <= '0;
    end else if (!stall) begin
      rsp_valid <= |fire_rd;
      if (|fire_rd) begin
        tmask_q <= fire_rd;
        tag_q   <= leader_tag;
      end
    end
  // remembers which bank feeds each lane; data itself stays in the bank read register
  always_ff @(posedge clk)
    if (!stall && |fire_rd)
      for (int i = 0; i < NUM_REQS; i++) rsp_bank[i] <= bank[i];
  always_comb begin
    rsp.tmask = tmask_q;
    rsp.tag   = tag_q;
    for (int i = 0; i < NUM_REQS; i++) rsp.data[i] = tmask_q[i] ? bank_rdata[rsp_bank[i]] : '0;
  end
  assign rsp_tmask = rsp.tmask;
  assign rsp_data  = rsp.data;
  assign rsp_tag   = rsp.tag;
endmodule

// File: tb/tb_vx_smem_responder.sv
// tb_vx_smem_responder: randomized and directed checks of vx_smem_responder against a word-level model
module tb_vx_smem_responder;
  localparam int N = 4;
`ifdef SMEM_RD_BCAST_EN
  localparam int BC_RESP = 1;
`else
  localparam int BC_RESP = 4;
`endif
  logic         clk = 0, reset = 1;
  logic [3:0]   req_valid = 0, req_rw = 0, req_ready;
  logic [119:0] req_addr = 0;
  logic [15:0]  req_byteen = 0;
  logic [127:0] req_data = 0;
  logic [31:0]  req_tag = 0;
  logic         rsp_valid, rsp_ready = 1;
  logic [3:0]   rsp_tmask;
  logic [127:0] rsp_data;
  logic [7:0]   rsp_tag;
  int           passed = 0, total = 0;
  logic [31:0]  mem_m [4096];
  logic         exp_valid = 0;
  logic [3:0]   exp_tmask = 0, r;
  logic [127:0] exp_data = 0;
  logic [7:0]   exp_tag = 0;

  always #5 clk = ~clk;

  vx_smem_responder dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr),
    .req_byteen(req_byteen), .req_data(req_data), .req_tag(req_tag), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_tmask(rsp_tmask), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rsp_ready(rsp_ready)
  );

  // which lanes the responder should accept this cycle, from the arbitration rules
  function automatic logic [3:0] model_ready();
    logic [3:0]  res = 0;
    int          owner [4] = '{-1, -1, -1, -1};
    int          lead = -1;
    int          b;
    logic [29:0] a;
    if (exp_valid && !rsp_ready) return 0;
    for (int i = 0; i < N; i++) if (req_valid[i] && lead < 0) lead = i;
    if (lead < 0) return 0;
    for (int i = 0; i < N; i++) begin
      a = req_addr[i*30 +: 30];
      b = int'(a[1:0]);
      if (!req_valid[i] || req_tag[i*8 +: 8] != req_tag[lead*8 +: 8]) continue;
      if (owner[b] < 0) begin
        owner[b] = i;
        res[i] = 1;
      end
`ifdef SMEM_RD_BCAST_EN
      else if (!req_rw[i] && !req_rw[owner[b]] && a == req_addr[owner[b]*30 +: 30]) res[i] = 1;
`endif
    end
    return res;
  endfunction

  // advance the model across one clock edge and retire accepted lanes
  task automatic tick();
    logic [3:0]   acc, rd;
    logic [127:0] d;
    logic [7:0]   lt;
    acc = model_ready();
    rd  = acc & ~req_rw;
    d   = '0;
    lt  = '0;
    for (int i = N - 1; i >= 0; i--) if (req_valid[i]) lt = req_tag[i*8 +: 8];
    if (!(exp_valid && !rsp_ready)) begin
      for (int i = 0; i < N; i++) if (rd[i]) d[i*32 +: 32] = mem_m[req_addr[i*30 +: 12]];
      for (int i = 0; i < N; i++)
        if (acc[i] && req_rw[i])
          for (int k = 0; k < 4; k++)
            if (req_byteen[i*4 + k]) mem_m[req_addr[i*30 +: 12]][k*8 +: 8] = req_data[i*32 + k*8 +: 8];
      exp_valid = |rd;
      if (|rd) begin
        exp_tmask = rd;
        exp_data  = d;
        exp_tag   = lt;
      end
    end
    @(posedge clk);
    #1 req_valid = req_valid & ~acc;
    @(negedge clk);
  endtask

  task automatic set_lane(int i, logic rw, logic [29:0] a, logic [3:0] be, logic [31:0] d, logic [7:0] t);
    req_valid[i]         = 1;
    req_rw[i]            = rw;
    req_addr[i*30 +: 30] = a;
    req_byteen[i*4 +: 4] = be;
    req_data[i*32 +: 32] = d;
    req_tag[i*8 +: 8]    = t;
  endtask

  task automatic test_reset();
    total++; if (rsp_valid !== 1'b0) $display("FAIL reset rsp_valid got %b want 0", rsp_valid); else passed++;
    total++; if (rsp_tmask !== 4'b0) $display("FAIL reset rsp_tmask got %b want 0", rsp_tmask); else passed++;
    total++; if (rsp_data !== 128'b0) $display("FAIL reset rsp_data got %h want 0", rsp_data); else passed++;
    total++; if (rsp_tag !== 8'b0) $display("FAIL reset rsp_tag got %h want 0", rsp_tag); else passed++;
    reset = 0;
  endtask

  task automatic test_write_read();
    for (int s = 0; s < 6; s++) begin
      for (int i = 0; i < N; i++)
        if (s < 4) set_lane(i, 1, 30'(4 * s + i), 4'hf, $urandom, 8'd1);
        else set_lane(i, s == 4, 30'(i), 4'hf, 32'h10 + i, s == 4 ? 8'd2 : 8'd3);
      for (int c = 0; c < 20 && (|req_valid || exp_valid); c++) begin
        #1 r = model_ready();
        total++; if (req_ready !== r) $display("FAIL wr_rd ready s%0d c%0d got %b want %b", s, c, req_ready, r); else passed++;
        total++; if (rsp_valid !== exp_valid || (exp_valid && {rsp_tmask, rsp_tag, rsp_data} !== {exp_tmask, exp_tag, exp_data}))
          $display("FAIL wr_rd rsp s%0d c%0d got v%b m%b t%h d%h want v%b m%b t%h d%h", s, c, rsp_valid, rsp_tmask, rsp_tag, rsp_data, exp_valid, exp_tmask, exp_tag, exp_data);
        else passed++;
        if (s >= 4 && c == 0) begin
          total++; if (req_ready !== 4'b1111) $display("FAIL wr_rd all_ready got %b want 1111", req_ready); else passed++;
        end
        if (s == 5 && c == 1) begin
          total++; if ({rsp_valid, rsp_tmask, rsp_tag, rsp_data} !== {1'b1, 4'b1111, 8'h03, 32'h13, 32'h12, 32'h11, 32'h10})
            $display("FAIL wr_rd plan_rsp got v%b m%b t%h d%h want v1 m1111 t03 d00000013000000120000001100000010", rsp_valid, rsp_tmask, rsp_tag, rsp_data);
          else passed++;
        end
        tick();
      end
      total++; if (req_valid !== 4'b0 || rsp_valid !== 1'b0) $display("FAIL wr_rd drain s%0d got pending %b rsp %b want 0 0", s, req_valid, rsp_valid); else passed++;
    end
  endtask

  task automatic test_conflict();
    set_lane(0, 0, 30'h0, 4'hf, 0, 8'd7);
    set_lane(1, 0, 30'h4, 4'hf, 0, 8'd7);
    set_lane(2, 0, 30'h2, 4'hf, 0, 8'd7);
    set_lane(3, 0, 30'h3, 4'hf, 0, 8'd7);
    for (int c = 0; c < 20 && (|req_valid || exp_valid); c++) begin
      #1 r = model_ready();
      total++; if (req_ready !== r) $display("FAIL conflict ready c%0d got %b want %b", c, req_ready, r); else passed++;
      total++; if (rsp_valid !== exp_valid || (exp_valid && {rsp_tmask, rsp_tag, rsp_data} !== {exp_tmask, exp_tag, exp_data}))
        $display("FAIL conflict rsp c%0d got v%b m%b t%h d%h want v%b m%b t%h d%h", c, rsp_valid, rsp_tmask, rsp_tag, rsp_data, exp_valid, exp_tmask, exp_tag, exp_data);
      else passed++;
      if (c < 2) begin
        total++; if (req_ready !== (c == 0 ? 4'b1101 : 4'b0010)) $display("FAIL conflict plan_ready c%0d got %b want %b", c, req_ready, c == 0 ? 4'b1101 : 4'b0010); else passed++;
      end
      tick();
    end
    total++; if (req_valid !== 4'b0 || rsp_valid !== 1'b0) $display("FAIL conflict drain got pending %b rsp %b want 0 0", req_valid, rsp_valid); else passed++;
  endtask

  task automatic test_byteen();
    for (int s = 0; s < 3; s++) begin
      if (s == 0) set_lane(2, 1, 30'h5, 4'hf, 32'h11223344, 8'd1);
      else if (s == 1) set_lane(2, 1, 30'h5, 4'b0010, 32'hAABBCCDD, 8'd1);
      else set_lane(2, 0, 30'h5, 4'h0, 0, 8'd2);
      for (int c = 0; c < 20 && (|req_valid || exp_valid); c++) begin
        #1 r = model_ready();
        total++; if (req_ready !== r) $display("FAIL byteen ready s%0d c%0d got %b want %b", s, c, req_ready, r); else passed++;
        total++; if (rsp_valid !== exp_valid || (exp_valid && {rsp_tmask, rsp_tag, rsp_data} !== {exp_tmask, exp_tag, exp_data}))
          $display("FAIL byteen rsp s%0d c%0d got v%b m%b t%h d%h want v%b m%b t%h d%h", s, c, rsp_valid, rsp_tmask, rsp_tag, rsp_data, exp_valid, exp_tmask, exp_tag, exp_data);
        else passed++;
        if (s == 2 && c == 1) begin
          total++; if (rsp_data[95:64] !== 32'h1122CC44) $display("FAIL byteen merged got %h want 1122cc44", rsp_data[95:64]); else passed++;
        end
        tick();
      end
      total++; if (req_valid !== 4'b0 || rsp_valid !== 1'b0) $display("FAIL byteen drain s%0d got pending %b rsp %b want 0 0", s, req_valid, rsp_valid); else passed++;
    end
  endtask

  task automatic test_stall();
    logic [140:0] held;
    set_lane(0, 0, 30'h0, 4'hf, 0, 8'd1);
    set_lane(1, 0, 30'h1, 4'hf, 0, 8'd2);
    for (int c = 0; c < 20 && (|req_valid || exp_valid); c++) begin
      rsp_ready = !(c >= 1 && c <= 3);
      #1 r = model_ready();
      total++; if (req_ready !== r) $display("FAIL stall ready c%0d got %b want %b", c, req_ready, r); else passed++;
      total++; if (rsp_valid !== exp_valid || (exp_valid && {rsp_tmask, rsp_tag, rsp_data} !== {exp_tmask, exp_tag, exp_data}))
        $display("FAIL stall rsp c%0d got v%b m%b t%h d%h want v%b m%b t%h d%h", c, rsp_valid, rsp_tmask, rsp_tag, rsp_data, exp_valid, exp_tmask, exp_tag, exp_data);
      else passed++;
      if (c == 1) held = {rsp_valid, rsp_tmask, rsp_tag, rsp_data};
      if (c >= 2 && c <= 4) begin
        total++; if ({rsp_valid, rsp_tmask, rsp_tag, rsp_data} !== held) $display("FAIL stall hold c%0d got %h want %h", c, {rsp_valid, rsp_tmask, rsp_tag, rsp_data}, held); else passed++;
      end
      if (c >= 1 && c <= 4) begin
        total++; if (req_ready !== (c == 4 ? 4'b0010 : 4'b0000)) $display("FAIL stall plan_ready c%0d got %b want %b", c, req_ready, c == 4 ? 4'b0010 : 4'b0000); else passed++;
      end
      tick();
    end
    rsp_ready = 1;
    total++; if (req_valid !== 4'b0 || rsp_valid !== 1'b0) $display("FAIL stall drain got pending %b rsp %b want 0 0", req_valid, rsp_valid); else passed++;
  endtask

  task automatic test_tags();
    set_lane(0, 0, 30'h0, 4'hf, 0, 8'd5);
    set_lane(1, 0, 30'h1, 4'hf, 0, 8'd6);
    for (int c = 0; c < 20 && (|req_valid || exp_valid); c++) begin
      #1 r = model_ready();
      total++; if (req_ready !== r) $display("FAIL tags ready c%0d got %b want %b", c, req_ready, r); else passed++;
      total++; if (rsp_valid !== exp_valid || (exp_valid && {rsp_tmask, rsp_tag, rsp_data} !== {exp_tmask, exp_tag, exp_data}))
        $display("FAIL tags rsp c%0d got v%b m%b t%h d%h want v%b m%b t%h d%h", c, rsp_valid, rsp_tmask, rsp_tag, rsp_data, exp_valid, exp_tmask, exp_tag, exp_data);
      else passed++;
      if (c == 1 || c == 2) begin
        total++; if (rsp_tag !== (c == 1 ? 8'd5 : 8'd6)) $display("FAIL tags plan_tag c%0d got %0d want %0d", c, rsp_tag, c == 1 ? 5 : 6); else passed++;
      end
      tick();
    end
    total++; if (req_valid !== 4'b0 || rsp_valid !== 1'b0) $display("FAIL tags drain got pending %b rsp %b want 0 0", req_valid, rsp_valid); else passed++;
  endtask

  task automatic test_bcast();
    int nresp = 0;
    for (int i = 0; i < N; i++) set_lane(i, 0, 30'h8, 4'hf, 0, 8'd9);
    for (int c = 0; c < 20 && (|req_valid || exp_valid); c++) begin
      #1 r = model_ready();
      total++; if (req_ready !== r) $display("FAIL bcast ready c%0d got %b want %b", c, req_ready, r); else passed++;
      total++; if (rsp_valid !== exp_valid || (exp_valid && {rsp_tmask, rsp_tag, rsp_data} !== {exp_tmask, exp_tag, exp_data}))
        $display("FAIL bcast rsp c%0d got v%b m%b t%h d%h want v%b m%b t%h d%h", c, rsp_valid, rsp_tmask, rsp_tag, rsp_data, exp_valid, exp_tmask, exp_tag, exp_data);
      else passed++;
      if (rsp_valid && rsp_ready) nresp++;
      tick();
    end
    total++; if (nresp != BC_RESP) $display("FAIL bcast responses got %0d want %0d", nresp, BC_RESP); else passed++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 3) != 0)
          set_lane(i, 1'($urandom), {18'($urandom), 12'($urandom_range(0, 15))}, 4'($urandom), $urandom, 8'($urandom_range(1, 2)));
      for (int c = 0; c < 60 && (|req_valid || exp_valid); c++) begin
        rsp_ready = $urandom_range(0, 3) != 0;
        #1 r = model_ready();
        total++; if (req_ready !== r) $display("FAIL random ready n%0d c%0d got %b want %b", n, c, req_ready, r); else passed++;
        total++; if (rsp_valid !== exp_valid || (exp_valid && {rsp_tmask, rsp_tag, rsp_data} !== {exp_tmask, exp_tag, exp_data}))
          $display("FAIL random rsp n%0d c%0d got v%b m%b t%h d%h want v%b m%b t%h d%h", n, c, rsp_valid, rsp_tmask, rsp_tag, rsp_data, exp_valid, exp_tmask, exp_tag, exp_data);
        else passed++;
        tick();
      end
      rsp_ready = 1;
      total++; if (req_valid !== 4'b0 || rsp_valid !== 1'b0) $display("FAIL random drain n%0d got pending %b rsp %b want 0 0", n, req_valid, rsp_valid); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    set_lane(0, 0, 30'h3, 4'hf, 0, 8'd4);
    #1 tick();
    total++; if (rsp_valid !== 1'b1) $display("FAIL reset_mid pending got %b want 1", rsp_valid); else passed++;
    #2 reset = 1;
    #1;
    total++; if ({rsp_valid, rsp_tmask, rsp_tag, rsp_data} !== 141'b0) $display("FAIL reset_mid cleared got v%b m%b t%h d%h want all 0", rsp_valid, rsp_tmask, rsp_tag, rsp_data); else passed++;
    @(negedge clk) reset = 0;
    exp_valid = 0;
    #1;
    total++; if (rsp_valid !== 1'b0) $display("FAIL reset_mid after got %b want 0", rsp_valid); else passed++;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    test_reset();
    test_write_read();
    test_conflict();
    test_byteen();
    test_stall();
    test_tags();
    test_bcast();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired after %0d checks", total);
    $fatal(1);
  end
endmodule

// File: doc/vx_smem_responder.md
Name: vx_smem_responder

Overview:
Responder end of the per-thread dcache request/response interface. Serves an LSU-side initiator from a banked on-core scratchpad (shared memory).
- Accepts up to NUM_REQS per-thread requests per cycle and resolves bank conflicts by serialising them.
- Writes commit silently with no response.
- Reads return one grouped response (tmask + per-lane data + tag) one cycle after acceptance.

Parameters:
NUM_REQS, 4, number of thread lanes
NUM_BANKS, 4, power of 2; bank = word_addr[log2(NUM_BANKS)-1:0]
SIZE, 16384, capacity in bytes; ROWS = SIZE/(4*NUM_BANKS)
TAG_WIDTH, 8, request/response tag width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQS  per-lane request valid
req_rw  in  NUM_REQS  1=write, 0=read
req_addr  in  NUM_REQS*30  word address
req_byteen  in  NUM_REQS*4  byte enables (writes)
req_data  in  NUM_REQS*32  write data
req_tag  in  NUM_REQS*TAG_WIDTH  per-lane tag
req_ready  out  NUM_REQS  per-lane accept
rsp_valid  out  1  read response valid
rsp_tmask  out  NUM_REQS  lanes carried in response
rsp_data  out  NUM_REQS*32  read data per lane
rsp_tag  out  TAG_WIDTH  response tag
rsp_ready  in  1  initiator accepts response

Behaviour:
- Reset (asynchronous, active-high): rsp_valid=0, rsp_tmask=0, rsp_data=0, rsp_tag=0. Memory contents are not reset. An in-flight response is dropped when reset asserts mid-operation.
- Request fire on lane i = req_valid[i] & req_ready[i].
- stall = rsp_valid & ~rsp_ready. While stall: req_ready = 0 on all lanes, and the rsp_* outputs are held stable.
- Arbitration is combinational and evaluated each cycle:
  - leader = lowest valid lane.
  - Candidates = valid lanes whose tag equals the leader's tag. Other tags wait for a later cycle.
  - Per bank, the lowest-indexed candidate wins.
  - req_ready[i] = ~stall & winner[i].
- Row index = word_addr >> log2(NUM_BANKS), truncated to log2(ROWS) bits. Upper address bits are ignored (the address wraps).
- Writes: the byte-enabled update commits at the clock edge of acceptance. A read in a later cycle observes the new data. Writes never produce a response.
- Reads: if any read is accepted at cycle T, then at T+1:
  - rsp_valid=1;
  - rsp_tmask = accepted read lanes;
  - rsp_data = 32-bit word per lane (0 for lanes outside tmask);
  - rsp_tag = leader tag.
- Mixed reads and writes in one cycle: writes commit, and only read lanes appear in tmask.
- Response register:
  - loads when ~stall;
  - clears rsp_valid when the response fires and no new read is accepted.
  - Throughput is one response per cycle while rsp_ready=1. A response fire and a new acceptance may occur in the same cycle.
- Conflicts: lanes that lose arbitration keep req_valid asserted and are served in following cycles. Each service cycle produces a separate response carrying the same tag; the initiator tracks the remaining mask.
- Cycles with no accepted read leave the response register unchanged (unless the held response fires).

Optional Feature:
SMEM_RD_BCAST_EN.
- Defined: a read lane that loses bank arbitration but has the same word address as its bank's winner, and the winner is also a read, is also accepted. It receives the same data in the same response.
- Undefined: such lanes are serialised like any other conflict.

Decomposition:
- Shared package vx_smem_pkg holds:
  - constants BANK_SEL_BITS = log2(NUM_BANKS) and ROW_BITS = log2(ROWS);
  - typedef smem_req_t {rw, addr, byteen, data, tag};
  - typedef smem_rsp_t {tmask, data, tag}.
- One sub-module, vx_smem_bank: single-port ROWS x 32-bit memory with byte-write enable and registered read. It is instantiated NUM_BANKS times; the top level holds arbitration and the response register.

Test Plan:
1. Write lanes 0-3 at word addr 0-3 (distinct banks) with data 0x10+i; next cycle read the same addresses with tag 0x3 -> req_ready=1111 in both cycles; one cycle after the read, rsp_valid=1, tmask=1111, data=0x10..0x13, tag=0x3.
2. Read lanes 0,1 at words 0x0 and 0x4 (both bank 0), lanes 2,3 at words 0x2 and 0x3 -> cycle 1 req_ready=1101, cycle 2 req_ready=0010; two responses with tmask 1101 then 0010, same tag.
3. Word 0x5 holds 0x11223344; write 0xAABBCCDD with byteen=0010; read word 0x5 -> data 0x1122CC44.
4. Response pending with rsp_ready=0 for 3 cycles -> req_ready=0000 and rsp_* stable throughout; on rsp_ready=1 the response fires and the next read is accepted in the same cycle.
5. Lane0 tag 5 and lane1 tag 6, different banks -> cycle 1 ready=01 with response tag 5; cycle 2 ready=10 with response tag 6.
6. All 4 lanes read word 0x8 -> SMEM_RD_BCAST_EN defined: one response, tmask=1111. Undefined: four responses with tmasks 0001, 0010, 0100, 1000. Reset asserted while a response is pending -> rsp_valid=0 immediately.
